// File: rtl/cnn_conv2_pkg.sv
// Shared widths, constants and FSM encoding for the conv2 accumulate/requantise stage.
package cnn_conv2_pkg;

  localparam int PROD_W     = 23;
  localparam int BIAS_W     = 23;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 9;
  localparam int KERNEL_LEN = 150;
  localparam int SHIFT      = 13;

  // A single-beat kernel still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(KERNEL_LEN);

  typedef enum logic [1:0] {
    S_ACC,
    S_RND,
    S_OUT
  } state_e;

endpackage

// File: rtl/cnn_conv2_acc_requant_if.sv
// Product-in / activation-out stream bundle between the conv2 multiplier, accumulator and pooling writer.
interface cnn_conv2_acc_requant_if #(
  parameter int PROD_W = cnn_conv2_pkg::PROD_W,
  parameter int BIAS_W = cnn_conv2_pkg::BIAS_W,
  parameter int OUT_W  = cnn_conv2_pkg::OUT_W
);

  logic signed [PROD_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [BIAS_W-1:0] bias_in;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, bias_in, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, bias_in, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

endinterface

// File: rtl/cnn_requant_relu_sat.sv
// Combinational ACC_W -> OUT_W requantiser: ReLU, round-half-up right shift, upper saturation.
module cnn_requant_relu_sat #(
  parameter int ACC_W = cnn_conv2_pkg::ACC_W,
  parameter int SHIFT = cnn_conv2_pkg::SHIFT,
  parameter int OUT_W = cnn_conv2_pkg::OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    sat_out
);

  localparam logic [ACC_W:0] HALF  = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] Q_MAX = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);

  // One extra bit so the rounding add cannot wrap near the top of the range.
  logic [ACC_W:0] relu_val;
  logic [ACC_W:0] rounded;
  logic [ACC_W:0] shifted;

  // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
  always_comb begin
    relu_val = acc_in[ACC_W-1] ? '0 : {1'b0, acc_in};
    rounded  = relu_val + HALF;
    shifted  = rounded >> SHIFT;
    if (shifted > Q_MAX) begin
      q_out   = Q_MAX[OUT_W-1:0];
      sat_out = 1'b1;
    end else begin
      q_out   = shifted[OUT_W-1:0];
      sat_out = 1'b0;
    end
  end

endmodule

// File: rtl/cnn_conv2_acc_requant.sv
// Accumulates KERNEL_LEN products plus a channel bias, then requantises one activation per group.
module cnn_conv2_acc_requant #(
  parameter int PROD_W     = cnn_conv2_pkg::PROD_W,
  parameter int BIAS_W     = cnn_conv2_pkg::BIAS_W,
  parameter int ACC_W      = cnn_conv2_pkg::ACC_W,
  parameter int KERNEL_LEN = cnn_conv2_pkg::KERNEL_LEN,
  parameter int SHIFT      = cnn_conv2_pkg::SHIFT,
  parameter int OUT_W      = cnn_conv2_pkg::OUT_W
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  cnn_conv2_acc_requant_if.slave        bus,
  output logic                          busy
);

  import cnn_conv2_pkg::state_e;
  import cnn_conv2_pkg::S_ACC;
  import cnn_conv2_pkg::S_RND;
  import cnn_conv2_pkg::S_OUT;
  import cnn_conv2_pkg::cnt_width;

  localparam int              CNT_W = cnt_width(KERNEL_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_LEN - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_valid_q, out_valid_d;

  logic signed [PROD_W-1:0] in_data_w;
  logic signed [BIAS_W-1:0] bias_w;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [OUT_W-1:0]  rq_data;
  logic                     rq_sat;
  logic                     beat;

  assign in_data_w = bus.in_data;
  assign bias_w    = bus.bias_in;
  assign prod_ext  = ACC_W'(in_data_w);
  assign bias_ext  = ACC_W'(bias_w);

  assign bus.in_ready = (state_q == S_ACC);
  assign beat         = bus.in_valid && bus.in_ready;

  cnn_requant_relu_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_requant (
    .acc_in  (acc_q),
    .q_out   (rq_data),
    .sat_out (rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_ACC: begin
        if (beat) begin
          // The first beat of a group seeds the sum with the bias instead of the stale total.
          acc_d = ((cnt_q == '0) ? bias_ext : acc_q) + prod_ext;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_RND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RND: begin
        out_data_d  = rq_data;
        out_sat_d   = rq_sat;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_sat_d   = 1'b0;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (cnt_q != '0) || (state_q != S_ACC);

endmodule

// File: tb/tb_cnn_conv2_acc_requant.sv
// Bench for cnn_conv2_acc_requant: directed tables, corner sequences and randomized groups vs. an arithmetic model.
module tb_cnn_conv2_acc_requant;

  localparam int K      = 150;
  localparam int SHIFT  = 13;
  localparam int OUT_W  = 9;
  localparam int Q_MAX  = (1 << (OUT_W - 1)) - 1;
  localparam int BUDGET = 400;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  logic busy0, busy1;

  always #5 ap_clk = ~ap_clk;

  cnn_conv2_acc_requant_if bus0 ();
  cnn_conv2_acc_requant_if bus1 ();

  cnn_conv2_acc_requant u_dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus0.slave),
    .busy     (busy0)
  );

  cnn_conv2_acc_requant #(.KERNEL_LEN(1)) u_dut_k1 (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus1.slave),
    .busy     (busy1)
  );

  int total = 0;
  int bad   = 0;
  int n_out0 = 0;

  always @(posedge ap_clk)
    if (ap_rst_n && bus0.out_valid && bus0.out_ready) n_out0++;

  typedef struct {
    string name;
    int    bias;
    int    beat;
    int    exp_data;
    int    exp_sat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: whole-group arithmetic straight from the requantisation rules.
  function automatic void ref_model(input longint sum, output int q, output int s);
    longint r, qq;
    r  = (sum < 0) ? 0 : sum;
    qq = (r + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT);
    if (qq > Q_MAX) begin q = Q_MAX; s = 1; end
    else            begin q = int'(qq); s = 0; end
  endfunction

  task automatic send0(input int d, input int b, input int max_gap);
    int gap;
    int g;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) tick();
    bus0.in_data  = 23'(d);
    bus0.bias_in  = 23'(b);
    bus0.in_valid = 1'b1;
    g = 0;
    while (!bus0.in_ready && g < BUDGET) begin tick(); g++; end
    if (!bus0.in_ready) check("beat_accept_timeout", 0, 1);
    tick();
    bus0.in_valid = 1'b0;
    bus0.in_data  = 23'($urandom);
    bus0.bias_in  = 23'($urandom);
  endtask

  // Called at #1 after the edge that accepted the last beat of a group.
  task automatic collect0(input string tag, input int exp_d, input int exp_s, input int hold);
    bus0.out_ready = (hold == 0);
    check({tag, "_valid_early"}, bus0.out_valid, 0);
    tick();
    check({tag, "_valid"}, bus0.out_valid, 1);
    check({tag, "_data"}, bus0.out_data, exp_d);
    check({tag, "_sat"}, bus0.out_sat, exp_s);
    check({tag, "_in_ready_low"}, bus0.in_ready, 0);
    check({tag, "_busy"}, busy0, 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold"}, {bus0.out_valid, bus0.out_sat, bus0.out_data, bus0.in_ready},
            {1'b1, 1'(exp_s), 9'(exp_d), 1'b0});
    end
    bus0.out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, bus0.out_valid, 0);
    check({tag, "_sat_idle"}, bus0.out_sat, 0);
    check({tag, "_in_ready_back"}, bus0.in_ready, 1);
    check({tag, "_busy_idle"}, busy0, 0);
  endtask

  vec_t gv[4];
  vec_t kv[9];

  initial begin
    int   dq[$];
    int   q, s, bias, range, hold, n_before;
    longint sum;

    gv[0] = '{"nominal",   0,       8192,  150, 0};
    gv[1] = '{"relu_neg",  81920,   -8192, 0,   0};
    gv[2] = '{"bias_pos",  2457600, -8192, 150, 0};
    gv[3] = '{"saturate",  0,       16384, 255, 1};

    kv[0] = '{"rnd_half",   0,        4096,     1,   0};
    kv[1] = '{"rnd_below",  0,        4095,     0,   0};
    kv[2] = '{"rnd_1p5",    0,        12288,    2,   0};
    kv[3] = '{"rnd_bias",   -1,       4097,     1,   0};
    kv[4] = '{"neg_small",  0,        -5000,    0,   0};
    kv[5] = '{"edge_sat",   0,        2093056,  255, 1};
    kv[6] = '{"edge_max",   0,        2093055,  255, 0};
    kv[7] = '{"sum_m1",     -4194304, 4194303,  0,   0};
    kv[8] = '{"big_sat",    4194303,  4194303,  255, 1};

    bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.bias_in = '0; bus0.out_ready = 1'b1;
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.bias_in = '0; bus1.out_ready = 1'b1;

    repeat (3) tick();
    check("rst_out_data", bus0.out_data, 0);
    check("rst_out_sat", bus0.out_sat, 0);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_busy", busy0, 0);
    ap_rst_n = 1'b1;
    tick();
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_busy_after", busy0, 0);

    // Directed 150-beat groups, plain handshake.
    foreach (gv[i]) begin
      for (int b = 0; b < K; b++) send0(gv[i].beat, (b == 0) ? gv[i].bias : int'($urandom), 0);
      collect0(gv[i].name, gv[i].exp_data, gv[i].exp_sat, 0);
    end

    // Single-beat kernel: every beat carries the bias and yields an output.
    foreach (kv[i]) begin
      check({kv[i].name, "_k1_in_ready"}, bus1.in_ready, 1);
      bus1.bias_in  = 23'(kv[i].bias);
      bus1.in_data  = 23'(kv[i].beat);
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check({kv[i].name, "_k1_early"}, bus1.out_valid, 0);
      tick();
      check({kv[i].name, "_k1_valid"}, bus1.out_valid, 1);
      check({kv[i].name, "_k1_data"}, bus1.out_data, kv[i].exp_data);
      check({kv[i].name, "_k1_sat"}, bus1.out_sat, kv[i].exp_sat);
      tick();
      check({kv[i].name, "_k1_back"}, {bus1.in_ready, bus1.out_valid}, 2'b10);
    end

    // Gaps plus a long stall on the output side.
    for (int b = 0; b < K; b++) send0(8192, (b == 0) ? 0 : int'($urandom), 3);
    collect0("stall", 150, 0, 10);
    for (int b = 0; b < K; b++) send0(16384, (b == 0) ? 0 : int'($urandom), 2);
    collect0("stall_sat", 255, 1, 10);

    // Randomized groups against the reference model.
    for (int g = 0; g < 8; g++) begin
      case ($urandom_range(0, 2))
        0:       range = 1 << 12;
        1:       range = 1 << 14;
        default: range = 1 << 22;
      endcase
      bias = int'($urandom_range(0, 2 * range - 1)) - range;
      sum  = bias;
      dq.delete();
      for (int b = 0; b < K; b++) begin
        dq.push_back(int'($urandom_range(0, 2 * range - 1)) - range);
        sum += dq[b];
      end
      ref_model(sum, q, s);
      hold = int'($urandom_range(0, 5));
      for (int b = 0; b < K; b++) send0(dq[b], (b == 0) ? bias : int'($urandom), 2);
      collect0($sformatf("rand%0d", g), q, s, hold);
    end

    // Reset in the middle of a group discards the partial sum.
    for (int b = 0; b < 70; b++) send0(int'($urandom_range(0, 65535)), int'($urandom), 1);
    ap_rst_n = 1'b0;
    tick();
    check("midrst_out_data", bus0.out_data, 0);
    check("midrst_out_valid", bus0.out_valid, 0);
    check("midrst_out_sat", bus0.out_sat, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_in_ready", bus0.in_ready, 1);
    ap_rst_n = 1'b1;
    n_before = n_out0;
    for (int b = 0; b < K; b++) send0(8192, (b == 0) ? 0 : int'($urandom), 0);
    collect0("after_rst", 150, 0, 0);
    check("after_rst_one_output", n_out0 - n_before, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
